// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared definitions for the boot-time program loader.
//   - state_e            : loader FSM state encoding
//   - *_DEFAULT          : default address width, data width and frame sync byte
//   - len_is_valid()     : frame length check (1 .. 2^ADD_WIDTH payload bytes)
package program_loader_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLen      = 3'd1,
        StData     = 3'd2,
        StCsum     = 3'd3,
        StDone     = 3'd4,
        StErrFlush = 3'd5
    } state_e;

    localparam int unsigned ADD_WIDTH_DEFAULT = 7;
    localparam int unsigned WIDTH_DEFAULT     = 8;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    // A length of zero is meaningless and anything above the memory depth would
    // make the address counter wrap inside a frame.
    function automatic logic len_is_valid(input int unsigned n, input int unsigned aw);
        return (n != 0) && (n <= (32'd1 << aw));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: load-link stream plus program-memory write port.
//   in_valid/in_data/in_ready : byte stream, transfer on in_valid && in_ready
//   pm_wr_en/pm_addr/pm_wr_data: registered program-memory write port
//   cpu_hold/load_done/load_err: boot status
// Modports: master = stream source / status sink, slave = the loader.
interface program_loader_if #(
    parameter int unsigned ADD_WIDTH = 7,
    parameter int unsigned WIDTH     = 8
) ();

    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 pm_wr_en;
    logic [ADD_WIDTH-1:0] pm_addr;
    logic [WIDTH-1:0]     pm_wr_data;
    logic                 cpu_hold;
    logic                 load_done;
    logic                 load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, pm_wr_en, pm_addr, pm_wr_data, cpu_hold, load_done, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, pm_wr_en, pm_addr, pm_wr_data, cpu_hold, load_done, load_err
    );

endinterface

// File: rtl/loader_checksum.sv
// loader_checksum: running mod-2^WIDTH byte sum for the program loader.
// Only instantiated when PROGRAM_LOADER_CHECKSUM_EN is defined.
//   clk, rst : clock, asynchronous active-low reset
//   i_clear  : zero the sum (start of frame)
//   i_add    : add i_data to the sum
//   i_data   : byte to add, also the value compared against the sum
//   o_match  : current sum equals i_data
module loader_checksum #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_add,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_match
);

    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_match = (r_sum == i_data);

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-time writer for the byte-wide CPU program memory.
// Accepts frames of SYNC_BYTE, length N, N payload bytes [, checksum] and
// writes each payload byte to consecutive addresses from 0. Holds the CPU in
// reset until a complete, valid image has been written.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : program_loader_if.slave (stream in, memory write port and status out)
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum
// byte to the frame and the loader_checksum accumulator that verifies it.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned      ADD_WIDTH = ADD_WIDTH_DEFAULT,
    parameter int unsigned      WIDTH     = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(SYNC_BYTE_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    state_e               r_state, w_state_next;
    logic [ADD_WIDTH-1:0] r_addr, w_addr_next;
    logic [WIDTH-1:0]     r_remain, w_remain_next;
    logic                 r_pm_wr_en, w_pm_wr_en_next;
    logic [ADD_WIDTH-1:0] r_pm_addr, w_pm_addr_next;
    logic [WIDTH-1:0]     r_pm_wr_data, w_pm_wr_data_next;
    logic                 r_cpu_hold, w_cpu_hold_next;
    logic                 r_load_done, w_load_done_next;
    logic                 r_load_err, w_load_err_next;
    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_is_sync;

    assign w_in_ready = (r_state != StErrFlush);
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_is_sync  = (bus.in_data == SYNC_BYTE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic w_csum_clear;
    logic w_csum_add;
    logic w_csum_match;

    loader_checksum #(
        .WIDTH (WIDTH)
    ) u_checksum (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_csum_clear),
        .i_add   (w_csum_add),
        .i_data  (bus.in_data),
        .o_match (w_csum_match)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_remain     <= '0;
            r_pm_wr_en   <= 1'b0;
            r_pm_addr    <= '0;
            r_pm_wr_data <= '0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_addr       <= w_addr_next;
            r_remain     <= w_remain_next;
            r_pm_wr_en   <= w_pm_wr_en_next;
            r_pm_addr    <= w_pm_addr_next;
            r_pm_wr_data <= w_pm_wr_data_next;
            r_cpu_hold   <= w_cpu_hold_next;
            r_load_done  <= w_load_done_next;
            r_load_err   <= w_load_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_remain_next     = r_remain;
        w_pm_wr_en_next   = 1'b0;
        w_pm_addr_next    = r_pm_addr;
        w_pm_wr_data_next = r_pm_wr_data;
        w_cpu_hold_next   = r_cpu_hold;
        w_load_done_next  = r_load_done;
        w_load_err_next   = r_load_err;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        w_csum_clear      = 1'b0;
        w_csum_add        = 1'b0;
`endif

        case (r_state)
            // DONE behaves like IDLE except that the CPU is released; a new
            // sync byte restarts the load either way.
            StIdle, StDone: begin
                if (w_xfer && w_is_sync) begin
                    w_addr_next      = '0;
                    w_cpu_hold_next  = 1'b1;
                    w_load_done_next = 1'b0;
                    w_load_err_next  = 1'b0;
                    w_state_next     = StLen;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_csum_clear     = 1'b1;
`endif
                end
            end

            StLen: begin
                if (w_xfer) begin
                    if (len_is_valid(32'(bus.in_data), ADD_WIDTH)) begin
                        w_remain_next = bus.in_data;
                        w_state_next  = StData;
                    end else begin
                        w_state_next  = StErrFlush;
                    end
                end
            end

            StData: begin
                if (w_xfer) begin
                    w_pm_wr_en_next   = 1'b1;
                    w_pm_addr_next    = r_addr;
                    w_pm_wr_data_next = bus.in_data;
                    w_addr_next       = r_addr + ADD_WIDTH'(1);
                    w_remain_next     = r_remain - WIDTH'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_csum_add        = 1'b1;
`endif
                    if (r_remain == WIDTH'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        w_state_next     = StCsum;
`else
                        w_state_next     = StDone;
                        w_cpu_hold_next  = 1'b0;
                        w_load_done_next = 1'b1;
`endif
                    end
                end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (w_xfer) begin
                    if (w_csum_match) begin
                        w_state_next     = StDone;
                        w_cpu_hold_next  = 1'b0;
                        w_load_done_next = 1'b1;
                    end else begin
                        w_state_next     = StErrFlush;
                    end
                end
            end
`endif

            // Single stall cycle; already-written memory is left as is.
            StErrFlush: begin
                w_state_next    = StIdle;
                w_load_err_next = 1'b1;
                w_cpu_hold_next = 1'b1;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.pm_wr_en   = r_pm_wr_en;
    assign bus.pm_addr    = r_pm_addr;
    assign bus.pm_wr_data = r_pm_wr_data;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader.
// Table of hand-written frames, a few multi-cycle sequences (timing, flush
// stall, mid-frame reset) and randomized streams checked against a
// frame-level reference model. Honours PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [7:0]  SYNC  = 8'hA5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADD_WIDTH(AW), .WIDTH(DW)) bus ();

    program_loader #(
        .ADD_WIDTH (AW),
        .WIDTH     (DW),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int          nb;
        logic [95:0] bytes;
        int          nwr;
        bit          done;
        bit          err;
        bit          hold;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    // Monitor: sampled on the falling edge, away from the active edge.
    wr_t  mon_wr_q[$];
    int   mon_cyc_q[$];
    int   cyc           = 0;
    int   ready_low     = 0;
    int   hold_fall_cyc = -1;
    logic prev_hold     = 1'b1;

    always @(negedge clk) begin
        if (bus.pm_wr_en) begin
            mon_wr_q.push_back('{addr: bus.pm_addr, data: bus.pm_wr_data});
            mon_cyc_q.push_back(cyc);
        end
        if (!bus.in_ready) ready_low <= ready_low + 1;
        if (prev_hold && !bus.cpu_hold) hold_fall_cyc <= cyc;
        prev_hold <= bus.cpu_hold;
        cyc <= cyc + 1;
    end

    // Reference model state
    logic [7:0] stim_q[$];
    wr_t        exp_q[$];
    bit         exp_done, exp_err, exp_hold;

    // Frame-level parse of the whole accepted byte sequence.
    task automatic run_model();
        int i = 0;
        int n = stim_q.size();
        int len, k;
        logic [7:0] sum;
        exp_q.delete();
        exp_done = 0; exp_err = 0; exp_hold = 1;
        while (i < n) begin
            if (stim_q[i] != SYNC) begin i++; continue; end
            i++;
            exp_hold = 1; exp_done = 0; exp_err = 0;
            if (i >= n) break;
            len = int'(stim_q[i]);
            i++;
            if (len == 0 || len > int'(DEPTH)) begin exp_err = 1; continue; end
            sum = 8'h00;
            k = 0;
            while (k < len && i < n) begin
                exp_q.push_back('{addr: k[6:0], data: stim_q[i]});
                sum = sum + stim_q[i];
                k++; i++;
            end
            if (k < len) break;
            if (CSUM_EN != 0) begin
                if (i >= n) break;
                if (stim_q[i] == sum) begin exp_done = 1; exp_hold = 0; end
                else exp_err = 1;
                i++;
            end else begin
                exp_done = 1; exp_hold = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 0;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL handshake: byte %0h not accepted within 8 cycles", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},   32'(bus.in_ready),   32'd1);
        check({tag, " pm_wr_en"},   32'(bus.pm_wr_en),   32'd0);
        check({tag, " pm_addr"},    32'(bus.pm_addr),    32'd0);
        check({tag, " pm_wr_data"}, 32'(bus.pm_wr_data), 32'd0);
        check({tag, " cpu_hold"},   32'(bus.cpu_hold),   32'd1);
        check({tag, " load_done"},  32'(bus.load_done),  32'd0);
        check({tag, " load_err"},   32'(bus.load_err),   32'd0);
    endtask

    // Compare captured writes since base against the model's expectation.
    task automatic check_writes(input string tag, input int base);
        int got = mon_wr_q.size() - base;
        check({tag, " write count"}, 32'(got), 32'(exp_q.size()));
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), 32'(mon_wr_q[base+i].addr),
                  32'(exp_q[i].addr));
            check($sformatf("%s wr%0d data", tag, i), 32'(mon_wr_q[base+i].data),
                  32'(exp_q[i].data));
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   base, c0, lr0;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        vecs.push_back('{name: "len0", nb: 2, bytes: 96'hA5_00_00000000_00000000_0000,
                         nwr: 0, done: 0, err: 1, hold: 1});
        vecs.push_back('{name: "len129", nb: 2, bytes: 96'hA5_81_00000000_00000000_0000,
                         nwr: 0, done: 0, err: 1, hold: 1});
        vecs.push_back('{name: "len_a5", nb: 2, bytes: 96'hA5_A5_00000000_00000000_0000,
                         nwr: 0, done: 0, err: 1, hold: 1});
        vecs.push_back('{name: "garbage", nb: 6, bytes: 96'h3C_FF_A5_01_7E_7E_00000000_0000,
                         nwr: 1, done: 1, err: 0, hold: 0});
        vecs.push_back('{name: "good4", nb: 7, bytes: 96'hA5_04_13_05_00_00_18_00000000_00,
                         nwr: 4, done: 1, err: 0, hold: 0});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        vecs.push_back('{name: "badcsum", nb: 7, bytes: 96'hA5_04_13_05_00_00_19_00000000_00,
                         nwr: 4, done: 0, err: 1, hold: 1});
`else
        vecs.push_back('{name: "badcsum", nb: 7, bytes: 96'hA5_04_13_05_00_00_19_00000000_00,
                         nwr: 4, done: 1, err: 0, hold: 0});
`endif
        vecs.push_back('{name: "restart", nb: 9, bytes: 96'hA5_02_11_22_33_A5_01_33_33_0000_00,
                         nwr: 3, done: 1, err: 0, hold: 0});
        vecs.push_back('{name: "err_then_ok", nb: 6, bytes: 96'hA5_00_A5_01_42_42_00000000_0000,
                         nwr: 1, done: 1, err: 0, hold: 0});

        // Reset values
        reset_dut();
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;

        // Table-driven frames
        foreach (vecs[v]) begin
            reset_dut();
            base = mon_wr_q.size();
            stim_q.delete();
            for (int i = 0; i < vecs[v].nb; i++) begin
                logic [7:0] b;
                b = vecs[v].bytes[95 - 8*i -: 8];
                stim_q.push_back(b);
                send_byte(b, 0);
            end
            repeat (4) @(posedge clk);
            @(negedge clk);
            run_model();
            check({vecs[v].name, " nwr"}, 32'(mon_wr_q.size() - base), 32'(vecs[v].nwr));
            check_writes(vecs[v].name, base);
            check({vecs[v].name, " load_done"}, 32'(bus.load_done), 32'(vecs[v].done));
            check({vecs[v].name, " load_err"},  32'(bus.load_err),  32'(vecs[v].err));
            check({vecs[v].name, " cpu_hold"},  32'(bus.cpu_hold),  32'(vecs[v].hold));
            @(posedge clk); #1;
        end

        // Write timing: consecutive write cycles and cpu_hold release point
        reset_dut();
        base = mon_wr_q.size();
        send_byte(8'hA5, 0); send_byte(8'h04, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h18, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("timing nwr", 32'(mon_wr_q.size() - base), 32'd4);
        if (mon_wr_q.size() - base >= 4) begin
            c0 = mon_cyc_q[base];
            for (int i = 1; i < 4; i++)
                check($sformatf("timing wr%0d consecutive", i),
                      32'(mon_cyc_q[base+i] - c0), 32'(i));
            check("timing hold fall", 32'(hold_fall_cyc - mon_cyc_q[base+3]), 32'(CSUM_EN));
        end
        @(posedge clk); #1;

        // Error flush stalls in_ready for exactly one cycle
        reset_dut();
        lr0 = ready_low;
        send_byte(8'hA5, 0); send_byte(8'h00, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("flush ready_low cycles", 32'(ready_low - lr0), 32'd1);
        @(posedge clk); #1;

        // Reset mid-frame, then a fresh frame loads from address 0
        reset_dut();
        send_byte(8'hA5, 0); send_byte(8'h04, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        base = mon_wr_q.size();
        stim_q.delete();
        stim_q.push_back(8'hA5); stim_q.push_back(8'h02); stim_q.push_back(8'h5A);
        stim_q.push_back(8'h6B); stim_q.push_back(8'hC5);
        foreach (stim_q[i]) send_byte(stim_q[i], 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        run_model();
        check("midreset reload nwr", 32'(mon_wr_q.size() - base), 32'd2);
        check_writes("midreset reload", base);
        check("midreset reload done", 32'(bus.load_done), 32'd1);
        @(posedge clk); #1;

        // Randomized streams with valid stalls
        for (int r = 0; r < 20; r++) begin
            int nfr;
            reset_dut();
            base = mon_wr_q.size();
            stim_q.delete();
            nfr = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++) begin
                int ng, kind, len;
                logic [7:0] sum, b;
                ng = int'($urandom_range(0, 2));
                for (int g = 0; g < ng; g++) stim_q.push_back(8'($urandom));
                stim_q.push_back(SYNC);
                kind = int'($urandom_range(0, 7));
                if (kind == 0)      len = 0;
                else if (kind == 1) len = int'($urandom_range(129, 255));
                else if (kind == 2) len = int'($urandom_range(100, 128));
                else                len = int'($urandom_range(1, 16));
                stim_q.push_back(8'(len));
                sum = 8'h00;
                if (kind != 0 && kind != 1) begin
                    for (int k = 0; k < len; k++) begin
                        b = 8'($urandom);
                        stim_q.push_back(b);
                        sum = sum + b;
                    end
                    if ($urandom_range(0, 3) == 0) sum = sum + 8'h01;
                    stim_q.push_back(sum);
                end
            end
            foreach (stim_q[i])
                send_byte(stim_q[i], ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
            repeat (4) @(posedge clk);
            @(negedge clk);
            run_model();
            check_writes($sformatf("rand%0d", r), base);
            check($sformatf("rand%0d load_done", r), 32'(bus.load_done), 32'(exp_done));
            check($sformatf("rand%0d load_err", r),  32'(bus.load_err),  32'(exp_err));
            check($sformatf("rand%0d cpu_hold", r),  32'(bus.cpu_hold),  32'(exp_hold));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the CPU's byte-wide program memory. It accepts a framed byte stream over a valid/ready handshake and drives the program-memory write port (write enable, address, data) one byte per accepted payload byte. It holds the CPU in reset until a complete, valid image is written. It sits between the external load link and the CPU's `pmWrEn`/`pm_addr`/`instructionIn` inputs.

## Interface
- `ADD_WIDTH`, 7: program-memory byte-address width; depth = 2^ADD_WIDTH.
- `WIDTH`, 8: stream and memory data width.
- `SYNC_BYTE`, 8'hA5: frame start marker.

- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  stream byte valid.
- `in_data`  input  WIDTH  stream byte.
- `in_ready`  output  1  loader can accept a byte.
- `pm_wr_en`  output  1  program-memory write strobe (to `pmWrEn`).
- `pm_addr`  output  ADD_WIDTH  write address (to `pm_addr`).
- `pm_wr_data`  output  WIDTH  write data (to `instructionIn`).
- `cpu_hold`  output  1  high = keep CPU in reset.
- `load_done`  output  1  high after a successful load, until the next frame starts.
- `load_err`  output  1  high after a failed frame, until the next frame starts.

## Operation
- Frame: SYNC_BYTE, length N (payload bytes), N payload bytes, then a checksum byte (see Configuration).
- A byte transfers when `in_valid && in_ready`. `in_ready` is high in every state except ERR_FLUSH.
- States:
  - IDLE: waits for a transfer equal to SYNC_BYTE; other bytes are discarded. On sync: clear address counter and checksum, set `cpu_hold`=1, clear `load_done`/`load_err`, go to LEN.
  - LEN: N=0 or N>2^ADD_WIDTH goes to ERR_FLUSH. Otherwise latch N and go to DATA.
  - DATA: each transfer issues one write at the current address, adds the byte to the checksum mod 2^WIDTH, and increments the address. After the Nth byte, go to CSUM if checksum is enabled, otherwise to DONE.
  - CSUM: a transfer equal to the running sum goes to DONE; any other value goes to ERR_FLUSH.
  - DONE: `cpu_hold`=0, `load_done`=1. A SYNC_BYTE transfer restarts as from IDLE; other bytes are ignored.
  - ERR_FLUSH: one cycle with `in_ready`=0. Then go to IDLE with `load_err`=1 and `cpu_hold`=1.
- Memory already written by a failed frame is not rolled back. `cpu_hold` stays high after any failure.
- The address counter never wraps within a frame, because the LEN check bounds N.

## Timing
- Reset values: `in_ready`=1, `pm_wr_en`=0, `pm_addr`=0, `pm_wr_data`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0. State = IDLE.
- Write latency: `pm_wr_en`, `pm_addr` and `pm_wr_data` are registered. They are valid the cycle after the payload transfer, and `pm_wr_en` is high for exactly that one cycle per byte.
- Back-to-back payload bytes produce consecutive write cycles with addresses 0,1,2,…
- `cpu_hold` deasserts on the cycle the FSM enters DONE, which is after the last write has issued.
- Reset asserted mid-frame: all outputs return to reset values immediately, the partial frame is abandoned and `cpu_hold`=1.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: CSUM state and checksum accumulator are compiled in, and the frame carries a trailing checksum byte.
- Not defined: no accumulator and no CSUM state. DATA goes directly to DONE after N bytes. `load_err` is raised only by an invalid length.

## Structure
- Shared package `program_loader_pkg`: state encoding localparams (IDLE, LEN, DATA, CSUM, DONE, ERR_FLUSH) and the default SYNC_BYTE constant.
- One sub-module: `loader_checksum`, an 8-bit mod-256 accumulator with clear/add/compare. It is instantiated only under the macro.

## Test plan
- A5, 04, 13, 05, 00, 00, csum 18 -> writes 13@0, 05@1, 00@2, 00@3 on consecutive cycles; `load_done`=1; `cpu_hold` falls after the write @3.
- Same frame with checksum 19 -> four writes occur; `load_err`=1; `cpu_hold` stays 1; `in_ready` low for one cycle.
- A5, 00 (and, separately, A5, 81 with ADD_WIDTH=7) -> no writes; `load_err`=1.
- Garbage 3C, FF before A5, 01, 7E, 7E -> garbage ignored; a single write 7E@0; `load_done`=1.
- Reset pulsed after the second payload byte of a 4-byte frame -> outputs return to reset values; a new full frame then loads from address 0.
- Stalls: `in_valid` toggled 1-0-1 mid-payload -> writes occur only on transfer cycles and addresses stay contiguous.
